// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the pipelined Thumb decoder:
//   - micro-op opcode encodings and SP/LR/PC register numbers
//   - dec_t : field bundle produced by decoding one 16-bit instruction
//   - decode_instr() : pure combinational decode of one instruction
//   - small helpers used by the PUSH/POP split sequencer (UOP_SPLIT_EN builds)
// -----------------------------------------------------------------------------
package decode_pkg;

  localparam logic [3:0] OP_PUSH      = 4'd0;
  localparam logic [3:0] OP_POP       = 4'd1;
  localparam logic [3:0] OP_SUB_SP    = 4'd2;
  localparam logic [3:0] OP_CMP       = 4'd3;
  localparam logic [3:0] OP_MOVS      = 4'd4;
  localparam logic [3:0] OP_MOV       = 4'd5;
  localparam logic [3:0] OP_LDR       = 4'd6;
  localparam logic [3:0] OP_STR       = 4'd7;
  localparam logic [3:0] OP_LDR_NOP   = 4'd8;
  localparam logic [3:0] OP_ADD_SP    = 4'd9;
  localparam logic [3:0] OP_BRANCH_NC = 4'd10;
  localparam logic [3:0] OP_ADDS_3OP  = 4'd11;
  localparam logic [3:0] OP_BRANCH_C  = 4'd12;
  localparam logic [3:0] OP_STRB      = 4'd13;
  localparam logic [3:0] OP_LDRB      = 4'd14;
  localparam logic [3:0] OP_ADDS_2OP  = 4'd15;

  localparam logic [3:0] REG_SP = 4'd13;
  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  // Widest decoded immediate is the unconditional branch: i[10:0]<<1.
  localparam int DEC_OFF_W = 12;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } split_state_t;

  typedef struct packed {
    logic [3:0]           opcode;
    logic [3:0]           reg1;
    logic [3:0]           reg2;
    logic [3:0]           reg3;
    logic [7:0]           rlist;
    logic [3:0]           cond;
    logic [DEC_OFF_W-1:0] offset;
    logic                 illegal;
  } dec_t;

  function automatic dec_t decode_instr(input logic [15:0] i);
    dec_t d;
    d = '0;
    case (i[15:12])
      4'hB: begin
        if (i[11:10] == 2'b01) begin
          d.opcode = OP_PUSH;
          d.reg1   = REG_LR;
          d.rlist  = i[7:0];
        end else if (i[11:10] == 2'b11) begin
          d.opcode = OP_POP;
          d.reg1   = REG_LR;
          d.rlist  = i[7:0];
        end else begin
          d.opcode = OP_SUB_SP;
          d.reg1   = REG_SP;
          d.reg3   = REG_SP;
          d.offset = DEC_OFF_W'({i[6:0], 2'b00});
        end
      end
      4'h2: begin
        d.opcode = i[11] ? OP_CMP : OP_MOVS;
        d.reg3   = {1'b0, i[10:8]};
        d.offset = DEC_OFF_W'(i[7:0]);
      end
      4'h4: begin
        if (i[11]) begin
          d.opcode = OP_LDR;
          d.reg1   = REG_PC;
          d.reg3   = {1'b0, i[10:8]};
          d.offset = DEC_OFF_W'({i[7:0], 2'b00});
        end else if (i[9:8] == 2'b10 && i[7:6] != 2'b00) begin
          // High-register MOV: i[7:6] selects which operand is in r8-r15.
          d.opcode = OP_MOV;
          case (i[7:6])
            2'b01: begin
              d.reg2 = {1'b1, i[2:0]};
              d.reg3 = {1'b0, i[5:3]};
            end
            2'b10: begin
              d.reg2 = {1'b0, i[5:3]};
              d.reg3 = {1'b1, i[2:0]};
            end
            default: begin
              d.reg2 = {1'b1, i[5:3]};
              d.reg3 = {1'b1, i[2:0]};
            end
          endcase
        end else begin
          d.illegal = 1'b1;
        end
      end
      4'h6: begin
        d.opcode = i[11] ? OP_LDR_NOP : OP_STR;
        d.reg1   = {1'b0, i[5:3]};
        d.reg3   = {1'b0, i[2:0]};
        d.offset = DEC_OFF_W'(i[10:6]);
      end
      4'hA: begin
        d.opcode = OP_ADD_SP;
        d.reg1   = REG_SP;
        d.reg3   = {1'b0, i[10:8]};
        d.offset = DEC_OFF_W'({i[7:0], 2'b00});
      end
      4'hE: begin
        d.opcode = OP_BRANCH_NC;
        d.offset = {i[10:0], 1'b0};
      end
      4'h1: begin
        d.opcode = OP_ADDS_3OP;
        d.reg2   = {1'b0, i[5:3]};
        d.reg3   = {1'b0, i[2:0]};
        d.offset = DEC_OFF_W'(i[8:6]);
      end
      4'hD: begin
        d.opcode = OP_BRANCH_C;
        d.cond   = i[11:8];
        d.offset = DEC_OFF_W'({i[7:0], 1'b0});
      end
      4'h5: begin
        d.opcode = i[11] ? OP_LDRB : OP_STRB;
        d.reg1   = {1'b0, i[8:6]};
        d.reg2   = {1'b0, i[5:3]};
        d.reg3   = {1'b0, i[2:0]};
      end
      4'h3: begin
        d.opcode = OP_ADDS_2OP;
        d.reg3   = {1'b0, i[10:8]};
        d.offset = DEC_OFF_W'(i[7:0]);
      end
      default: begin
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

  // An illegal encoding also carries opcode 0, so it must be excluded here.
  function automatic logic is_stack_op(input dec_t d);
    return !d.illegal && (d.opcode == OP_PUSH || d.opcode == OP_POP);
  endfunction

  // Transfer mask layout: bit 8 = LR, bits 7:0 = r7..r0.
  function automatic logic [3:0] lowest_set(input logic [8:0] m);
    logic [3:0] r;
    r = 4'd8;
    for (int b = 8; b >= 0; b--) begin
      if (m[b]) r = 4'(b);
    end
    return r;
  endfunction

  function automatic logic [3:0] highest_set(input logic [8:0] m);
    logic [3:0] r;
    r = 4'd0;
    for (int b = 0; b <= 8; b++) begin
      if (m[b]) r = 4'(b);
    end
    return r;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// -----------------------------------------------------------------------------
// instr_fifo
// DEPTH-entry instruction queue with a combinational head read, so the head
// can be decoded in the same cycle it becomes visible.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   flush           : synchronous clear (same effect as reset on the pointers)
//   push, din       : write din at the tail (caller guarantees !full)
//   pop             : drop the head (caller guarantees !empty)
//   dout            : current head entry
//   empty, full     : occupancy flags
// -----------------------------------------------------------------------------
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // One extra pointer bit separates the full and empty cases.
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
// Pipelined Thumb decoder: fetched instructions are queued in instr_fifo, the
// head is decoded combinationally and loaded into a registered micro-op output.
// Build option: define UOP_SPLIT_EN to expand PUSH/POP into one micro-op per
// transferred register (LR always included); otherwise PUSH/POP leave as a
// single micro-op and out_last is constant 1.
// Ports:
//   clk, reset               : clock, synchronous active-high reset
//   in_valid/in_ready/in_instr : fetch side handshake and instruction
//   flush                    : synchronous pipeline flush, highest priority
//   out_valid/out_ready      : execute side handshake
//   out_opcode, out_reg1..3, out_rlist, out_cond, out_offset,
//   out_illegal, out_last    : registered micro-op fields
// -----------------------------------------------------------------------------
module decode_pipe
  import decode_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int OFFSET_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [15:0]         in_instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_opcode,
  output logic [3:0]          out_reg1,
  output logic [3:0]          out_reg2,
  output logic [3:0]          out_reg3,
  output logic [7:0]          out_rlist,
  output logic [3:0]          out_cond,
  output logic [OFFSET_W-1:0] out_offset,
  output logic                out_illegal,
  output logic                out_last
);

  logic [15:0] head_instr;
  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_push;
  logic        fifo_pop;
  logic        can_load;
  dec_t        head_dec;

  logic                out_valid_q, out_valid_d;
  logic [3:0]          opcode_q, opcode_d;
  logic [3:0]          reg1_q, reg1_d;
  logic [3:0]          reg2_q, reg2_d;
  logic [3:0]          reg3_q, reg3_d;
  logic [7:0]          rlist_q, rlist_d;
  logic [3:0]          cond_q, cond_d;
  logic [OFFSET_W-1:0] offset_q, offset_d;
  logic                illegal_q, illegal_d;

  // A full queue keeps in_ready low even if the head pops this cycle.
  assign in_ready  = !fifo_full && !flush && !reset;
  assign fifo_push = in_valid && in_ready;
  // Output register may reload whenever it is empty or being accepted.
  assign can_load  = !out_valid_q || out_ready;
  assign head_dec  = decode_instr(head_instr);

  instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (16)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (fifo_push),
    .din   (in_instr),
    .pop   (fifo_pop),
    .dout  (head_instr),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

`ifdef UOP_SPLIT_EN
  split_state_t state_q, state_d;
  logic [8:0]   mask_q, mask_d;
  logic         last_q, last_d;
  logic [8:0]   cur_mask;
  logic [8:0]   rem_mask;
  logic [3:0]   pick;
`endif

  always_comb begin
    out_valid_d = out_valid_q;
    opcode_d    = opcode_q;
    reg1_d      = reg1_q;
    reg2_d      = reg2_q;
    reg3_d      = reg3_q;
    rlist_d     = rlist_q;
    cond_d      = cond_q;
    offset_d    = offset_q;
    illegal_d   = illegal_q;
    fifo_pop    = 1'b0;
`ifdef UOP_SPLIT_EN
    state_d  = state_q;
    mask_d   = mask_q;
    last_d   = last_q;
    cur_mask = '0;
    rem_mask = '0;
    pick     = '0;
`endif
    if (can_load) begin
      out_valid_d = 1'b0;
      if (!fifo_empty) begin
        out_valid_d = 1'b1;
        opcode_d    = head_dec.opcode;
        reg1_d      = head_dec.reg1;
        reg2_d      = head_dec.reg2;
        reg3_d      = head_dec.reg3;
        rlist_d     = head_dec.rlist;
        cond_d      = head_dec.cond;
        offset_d    = OFFSET_W'(head_dec.offset);
        illegal_d   = head_dec.illegal;
        fifo_pop    = 1'b1;
`ifdef UOP_SPLIT_EN
        last_d = 1'b1;
        if (is_stack_op(head_dec)) begin
          // First beat starts from the full list plus LR; later beats resume
          // from the remaining mask while the instruction stays at the head.
          cur_mask = (state_q == ST_SPLIT) ? mask_q : {1'b1, head_dec.rlist};
          pick     = (head_dec.opcode == OP_POP) ? lowest_set(cur_mask)
                                                 : highest_set(cur_mask);
          rem_mask = cur_mask & ~(9'd1 << pick);
          reg1_d   = REG_SP;
          reg3_d   = (pick == 4'd8) ? REG_LR : pick;
          last_d   = (rem_mask == 9'd0);
          fifo_pop = (rem_mask == 9'd0);
          mask_d   = rem_mask;
          state_d  = (rem_mask == 9'd0) ? ST_IDLE : ST_SPLIT;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_q <= 1'b0;
      opcode_q    <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      rlist_q     <= '0;
      cond_q      <= '0;
      offset_q    <= '0;
      illegal_q   <= 1'b0;
`ifdef UOP_SPLIT_EN
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      opcode_q    <= opcode_d;
      reg1_q      <= reg1_d;
      reg2_q      <= reg2_d;
      reg3_q      <= reg3_d;
      rlist_q     <= rlist_d;
      cond_q      <= cond_d;
      offset_q    <= offset_d;
      illegal_q   <= illegal_d;
`ifdef UOP_SPLIT_EN
      state_q     <= state_d;
      mask_q      <= mask_d;
      last_q      <= last_d;
`endif
    end
  end

  assign out_valid   = out_valid_q;
  assign out_opcode  = opcode_q;
  assign out_reg1    = reg1_q;
  assign out_reg2    = reg2_q;
  assign out_reg3    = reg3_q;
  assign out_rlist   = rlist_q;
  assign out_cond    = cond_q;
  assign out_offset  = offset_q;
  assign out_illegal = illegal_q;
`ifdef UOP_SPLIT_EN
  assign out_last    = last_q;
`else
  // Every micro-op is a whole instruction in this build.
  assign out_last    = 1'b1;
`endif

endmodule

// File: tb/tb_decode_pipe.sv
// -----------------------------------------------------------------------------
// tb_decode_pipe
// Scoreboard bench for decode_pipe: the driver pushes the expected micro-op
// sequence of every accepted instruction into a queue; a negedge monitor
// compares each output transfer against the queue head and checks that a
// stalled output holds steady.
// -----------------------------------------------------------------------------
module tb_decode_pipe;

  localparam int DEPTH    = 4;
  localparam int OFFSET_W = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_instr;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_opcode;
  logic [3:0]          out_reg1;
  logic [3:0]          out_reg2;
  logic [3:0]          out_reg3;
  logic [7:0]          out_rlist;
  logic [3:0]          out_cond;
  logic [OFFSET_W-1:0] out_offset;
  logic                out_illegal;
  logic                out_last;

  int checks   = 0;
  int failures = 0;
  int acc_cnt  = 0;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  r3;
    logic [7:0]  rl;
    logic [3:0]  cond;
    logic [15:0] off;
    logic        ill;
    logic        last;
  } uop_t;

  uop_t exp_q[$];

  always #5 clk = ~clk;

  decode_pipe #(
    .DEPTH    (DEPTH),
    .OFFSET_W (OFFSET_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_reg1    (out_reg1),
    .out_reg2    (out_reg2),
    .out_reg3    (out_reg3),
    .out_rlist   (out_rlist),
    .out_cond    (out_cond),
    .out_offset  (out_offset),
    .out_illegal (out_illegal),
    .out_last    (out_last)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: expected micro-ops of one instruction, from the
  // instruction table (register numbers and shifts as plain arithmetic).
  function automatic void model_push(input logic [15:0] i);
    uop_t u;
    uop_t v;
    int   regs[$];
    logic is_pop;
    logic stack;
    u = '0;
    u.last = 1'b1;
    stack  = 1'b0;
    is_pop = i[11];
    case (i[15:12])
      4'hB: begin
        if (i[10]) stack = 1'b1;
        else begin
          u.op = 4'd2; u.r1 = 4'd13; u.r3 = 4'd13;
          u.off = 16'(i[6:0]) * 16'd4;
        end
      end
      4'h2: begin
        u.op = i[11] ? 4'd3 : 4'd4;
        u.r3 = 4'(i[10:8]);
        u.off = 16'(i[7:0]);
      end
      4'h4: begin
        if (i[11]) begin
          u.op = 4'd6; u.r1 = 4'd15; u.r3 = 4'(i[10:8]);
          u.off = 16'(i[7:0]) * 16'd4;
        end else if (i[9:8] == 2'b10 && i[7:6] == 2'b01) begin
          u.op = 4'd5; u.r2 = 4'd8 + 4'(i[2:0]); u.r3 = 4'(i[5:3]);
        end else if (i[9:8] == 2'b10 && i[7:6] == 2'b10) begin
          u.op = 4'd5; u.r2 = 4'(i[5:3]); u.r3 = 4'd8 + 4'(i[2:0]);
        end else if (i[9:8] == 2'b10 && i[7:6] == 2'b11) begin
          u.op = 4'd5; u.r2 = 4'd8 + 4'(i[5:3]); u.r3 = 4'd8 + 4'(i[2:0]);
        end else begin
          u.ill = 1'b1;
        end
      end
      4'h6: begin
        u.op = i[11] ? 4'd8 : 4'd7;
        u.r1 = 4'(i[5:3]); u.r3 = 4'(i[2:0]);
        u.off = 16'(i[10:6]);
      end
      4'hA: begin
        u.op = 4'd9; u.r1 = 4'd13; u.r3 = 4'(i[10:8]);
        u.off = 16'(i[7:0]) * 16'd4;
      end
      4'hE: begin
        u.op = 4'd10; u.off = 16'(i[10:0]) * 16'd2;
      end
      4'h1: begin
        u.op = 4'd11; u.r2 = 4'(i[5:3]); u.r3 = 4'(i[2:0]);
        u.off = 16'(i[8:6]);
      end
      4'hD: begin
        u.op = 4'd12; u.cond = i[11:8]; u.off = 16'(i[7:0]) * 16'd2;
      end
      4'h5: begin
        u.op = i[11] ? 4'd14 : 4'd13;
        u.r1 = 4'(i[8:6]); u.r2 = 4'(i[5:3]); u.r3 = 4'(i[2:0]);
      end
      4'h3: begin
        u.op = 4'd15; u.r3 = 4'(i[10:8]); u.off = 16'(i[7:0]);
      end
      default: u.ill = 1'b1;
    endcase
    if (stack) begin
`ifdef UOP_SPLIT_EN
      if (!is_pop) begin
        regs.push_back(14);
        for (int r = 7; r >= 0; r--) if (i[r]) regs.push_back(r);
      end else begin
        for (int r = 0; r < 8; r++) if (i[r]) regs.push_back(r);
        regs.push_back(14);
      end
      foreach (regs[k]) begin
        v = '0;
        v.op   = is_pop ? 4'd1 : 4'd0;
        v.r1   = 4'd13;
        v.r3   = 4'(regs[k]);
        v.rl   = i[7:0];
        v.last = (k == regs.size() - 1);
        exp_q.push_back(v);
      end
`else
      u.op = is_pop ? 4'd1 : 4'd0;
      u.r1 = 4'd14;
      u.rl = i[7:0];
      exp_q.push_back(u);
`endif
    end else begin
      exp_q.push_back(u);
    end
  endfunction

  // Monitor: compare every output transfer, and check stall stability.
  logic [45:0] prev_out;
  logic        prev_stall = 1'b0;

  always @(negedge clk) begin
    logic [45:0] act;
    uop_t        e;
    act = {out_opcode, out_reg1, out_reg2, out_reg3, out_rlist, out_cond,
           16'(out_offset), out_illegal, out_last};
    if (reset) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (act !== prev_out || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL stall_hold actual=%h valid=%0b required=%h valid=1", act, out_valid, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL uop_unexpected actual=%h required=none", act);
        end else begin
          e = exp_q.pop_front();
          if (act !== e) begin
            failures++;
            $display("FAIL uop_mismatch actual=%h required=%h", act, e);
          end
        end
      end
      prev_stall <= out_valid && !out_ready && !flush;
      prev_out   <= act;
    end
  end

  // One cycle of stimulus, starting and ending just after a rising edge.
  task automatic cyc(input logic v, input logic [15:0] ins, input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    @(negedge clk);
    #1;
    if (fl) begin
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      exp_q.delete();
    end else if (v && in_ready) begin
      model_push(ins);
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 60) begin
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
      n++;
    end
    chk("drain_done", 64'(exp_q.size() == 0 && !out_valid), 64'd1);
  endtask

  logic [15:0] stall_list [6] = '{16'h2105, 16'h2B10, 16'hD1FE, 16'h0000, 16'h1A8B, 16'h3F22};

  initial begin
    int          acc0;
    logic [15:0] ins;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_fields", 64'({out_opcode, out_reg1, out_reg2, out_reg3, out_rlist,
                             out_cond, out_offset, out_illegal}), 64'd0);
`ifdef UOP_SPLIT_EN
    chk("reset_last", 64'(out_last), 64'd0);
`else
    chk("reset_last", 64'(out_last), 64'd1);
`endif
    reset = 1'b0;

    // Latency: accepted at edge k, visible after edge k+1.
    cyc(1'b1, 16'h2105, 1'b1, 1'b0);
    chk("lat_edge_k", 64'(out_valid), 64'd0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("lat_edge_k1", 64'(out_valid), 64'd1);
    drain();

    // Back-to-back CMP then conditional branch.
    cyc(1'b1, 16'h2B10, 1'b1, 1'b0);
    cyc(1'b1, 16'hD1FE, 1'b1, 1'b0);
    chk("b2b_first_valid", 64'(out_valid), 64'd1);
    cyc(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("b2b_second_valid", 64'(out_valid), 64'd1);
    drain();

    // PUSH {r0,r2,lr} and an illegal encoding.
    cyc(1'b1, 16'hB505, 1'b1, 1'b0);
    drain();
    cyc(1'b1, 16'h0000, 1'b1, 1'b0);
    drain();

    // Stall with a full queue: 5 of 6 accepted.
    acc0 = acc_cnt;
    for (int k = 0; k < 6; k++) cyc(1'b1, stall_list[k], 1'b0, 1'b0);
    chk("stall_accepted", 64'(acc_cnt - acc0), 64'd5);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    drain();

    // Flush while a POP is being emitted and the queue holds more work.
    cyc(1'b1, 16'hBD0F, 1'b1, 1'b0);
    cyc(1'b1, 16'h2105, 1'b1, 1'b0);
    cyc(1'b1, 16'h2B10, 1'b1, 1'b0);
    cyc(1'b0, 16'h0000, 1'b1, 1'b1);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 16'h0000, 1'b1, 1'b0);
      chk("flush_queue_empty", 64'(out_valid), 64'd0);
    end
    cyc(1'b1, 16'h2105, 1'b1, 1'b0);
    drain();

    // Randomized traffic with back-pressure and occasional flushes.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0)
        ins = {4'hB, 1'($urandom), 1'b1, 10'($urandom)};
      else
        ins = 16'($urandom);
      cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 49) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
